iir_sos_tdm: RTL and testbench
==============================

// Module: iir_sos_tdm
// PURPOSE
//  Multi-channel cascaded-biquad (second-order-section) IIR filter, Direct Form I per section.
//  Uses one time-multiplexed multiply-accumulate unit, so it replaces per-tap multipliers.
//  Sits in the analogue front-end between the ADC capture path and the trigger/decimation logic.
//  Per-channel delay-line state lets interleaved ADC channels share one filter.
// PARAMETERS
//  N_SECTIONS    2   number of cascaded biquads (>=1)
//  CHANNELS      2   independent channel state sets (>=1)
//  CH_WIDTH      1   width of channel index ports, >= clog2(CHANNELS), min 1
//  INPUT_WIDTH   12  signed sample input width
//  OUTPUT_WIDTH  12  signed sample output width (<= PRECISION)
//  PRECISION     16  signed width of inter-section signals and delay-line state
//  COEFF_WIDTH   16  signed coefficient width
//  Q             14  coefficient fractional bits (1.0 = 2^Q)
// PORTS
//  clk            in   1                           system clock, rising edge
//  rst_n          in   1                           asynchronous active-low reset
//  in_valid       in   1                           sample present on x/in_ch
//  in_ready       out  1                           block can accept a sample this cycle
//  in_ch          in   CH_WIDTH                    channel of x
//  x              in   INPUT_WIDTH                 signed input sample
//  packed_coeffs  in   N_SECTIONS*5*COEFF_WIDTH    per section s (LSB first): b0,b1,b2,a1,a2
//  state_clr      in   1                           zero all delay lines, all channels
//  out_valid      out  1                           one-cycle pulse: y/out_ch valid
//  out_ch         out  CH_WIDTH                    channel of y
//  y              out  OUTPUT_WIDTH                signed filtered sample
//  busy           out  1                           sample in flight
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM->IDLE; all delay lines zero; in_ready=0, out_valid=0, busy=0,
//    y=0, out_ch=0. in_ready rises on the first clk edge after rst_n deasserts.
//  - Reset mid-sample aborts the sample: no out_valid, all state cleared.
//  - Section eqn (a0 implicit 1): v = b0*u + b1*u1 + b2*u2 - a1*v1 - a2*v2.
//    u = section input; u1,u2 / v1,v2 = previous inputs/outputs for that channel+section.
//  - Section 0 input: x sign-extended to PRECISION. Section s>0 input: section s-1 output.
//  - Accumulator: PRECISION+COEFF_WIDTH+3 bits signed. Result = acc >>> Q (floor).
//    Result is reduced to PRECISION bits (wrap; saturate if macro set).
//  - y: final section output reduced to OUTPUT_WIDTH (wrap; saturate if macro set).
//  - FSM: IDLE -> MAC (5 cycles, one product per cycle) -> WB (1 cycle: shift u/v delay
//    lines, next section input) -> MAC for next section ... after last WB -> OUT -> IDLE.
//  - in_ready=1 only in IDLE with state_clr=0. Accept = in_valid & in_ready.
//    x, in_ch and packed_coeffs are registered on accept.
//    Coefficient changes mid-sample do not affect that sample.
//  - Latency: out_valid asserted exactly LAT = 6*N_SECTIONS+2 edges after the accepting edge,
//    for one cycle. No output backpressure. Throughput: one sample per LAT cycles.
//  - y/out_ch hold their value until the next out_valid. busy=1 from accept until out_valid.
//  - in_ch >= CHANNELS: sample accepted and processed through the timing, but dropped:
//    no out_valid, no state change.
//  - state_clr in IDLE: zeroes all CHANNELS*N_SECTIONS delay lines in one cycle.
//    A simultaneous in_valid is not accepted. state_clr while busy is ignored.
//  - Channels are fully independent: processing one channel never alters another's state.
// CONFIGURATION
//  IIR_SOS_SAT_EN defined: section results clamp to [-2^(PRECISION-1), 2^(PRECISION-1)-1],
//    and y clamps to the OUTPUT_WIDTH signed range.
//  IIR_SOS_SAT_EN undefined: two's-complement wrap (low bits kept). Port list is identical in
//    both builds.
// TESTING (defaults unless noted)
//  1 Hold rst_n=0 for 5 cycles, then release -> all outputs 0 during reset; in_ready=1 after
//    the first edge; busy=0.
//  2 Both sections b0=16384, others 0; x=100 ch0 -> out_valid exactly 14 edges after accept,
//    y=100, out_ch=0. x=-100 -> y=-100.
//  3 Sec0 b0=16384, a1=-8192; sec1 identity; ch0 impulse x=1000 then x=0 -> y=1000,500,250,125.
//  4 Interleave ch0 impulse (as in test 3) with ch1 x=0 every sample -> ch1 y always 0;
//    ch0 sequence is unchanged versus test 3.
//  5 N_SECTIONS=1, b0=32767, x=2047 -> SAT_EN: y=2047; without SAT_EN: y=-3
//    (4093 wrapped to 12 bits).
//  6 Pulse rst_n low mid-sample, then repeat test 3 step 1 -> no stray out_valid; y=1000.
//    Same with state_clr in IDLE instead of reset.

Source files
------------

// File: rtl/iir_sos_tdm.sv
// iir_sos_tdm: multi-channel cascaded-biquad IIR filter (Direct Form I per section)
// built around a single time-multiplexed multiply-accumulate unit.
// Each accepted sample walks through every section: five MAC cycles, then one
// write-back cycle that shifts that channel's delay lines.
// Build option: define IIR_SOS_SAT_EN to saturate section results and y;
// otherwise results wrap (two's complement, low bits kept).
module iir_sos_tdm #(
  parameter int N_SECTIONS   = 2,
  parameter int CHANNELS     = 2,
  parameter int CH_WIDTH     = 1,
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 12,
  parameter int PRECISION    = 16,
  parameter int COEFF_WIDTH  = 16,
  parameter int Q            = 14
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [CH_WIDTH-1:0]                   in_ch,
  input  logic signed [INPUT_WIDTH-1:0]         x,
  input  logic [N_SECTIONS*5*COEFF_WIDTH-1:0]   packed_coeffs,
  input  logic                                  state_clr,
  output logic                                  out_valid,
  output logic [CH_WIDTH-1:0]                   out_ch,
  output logic signed [OUTPUT_WIDTH-1:0]        y,
  output logic                                  busy
);

  localparam int PROD_W = PRECISION + COEFF_WIDTH;
  localparam int ACC_W  = PRECISION + COEFF_WIDTH + 3;
  localparam int SEC_W  = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
  localparam int COEF_TOTAL = N_SECTIONS * 5 * COEFF_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

`ifdef IIR_SOS_SAT_EN
  localparam logic signed [ACC_W-1:0] PREC_MAX =
    {{(ACC_W-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] PREC_MIN =
    {{(ACC_W-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};
  localparam logic signed [PRECISION-1:0] OUT_MAX =
    {{(PRECISION-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [PRECISION-1:0] OUT_MIN =
    {{(PRECISION-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  function automatic logic signed [PRECISION-1:0] reduce_prec(
    input logic signed [ACC_W-1:0] v);
    if (v > PREC_MAX)      reduce_prec = PREC_MAX[PRECISION-1:0];
    else if (v < PREC_MIN) reduce_prec = PREC_MIN[PRECISION-1:0];
    else                   reduce_prec = v[PRECISION-1:0];
  endfunction

  function automatic logic signed [OUTPUT_WIDTH-1:0] reduce_out(
    input logic signed [PRECISION-1:0] v);
    if (v > OUT_MAX)      reduce_out = OUT_MAX[OUTPUT_WIDTH-1:0];
    else if (v < OUT_MIN) reduce_out = OUT_MIN[OUTPUT_WIDTH-1:0];
    else                  reduce_out = v[OUTPUT_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [PRECISION-1:0] reduce_prec(
    input logic signed [ACC_W-1:0] v);
    reduce_prec = v[PRECISION-1:0];
  endfunction

  function automatic logic signed [OUTPUT_WIDTH-1:0] reduce_out(
    input logic signed [PRECISION-1:0] v);
    reduce_out = v[OUTPUT_WIDTH-1:0];
  endfunction
`endif

  // control state
  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [SEC_W-1:0]      sec_q, sec_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic                  ch_ok_q, ch_ok_d;
  logic                  ready_q;
  logic                  out_valid_q, out_valid_d;
  logic [CH_WIDTH-1:0]   out_ch_q, out_ch_d;
  logic signed [OUTPUT_WIDTH-1:0] y_q, y_d;

  // datapath registers
  logic signed [PRECISION-1:0]    u_q, u_d;
  logic [COEF_TOTAL-1:0]          coef_q, coef_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic signed [OUTPUT_WIDTH-1:0] y_pre_q, y_pre_d;

  // per-channel, per-section delay lines
  logic signed [PRECISION-1:0] u1_q [CHANNELS][N_SECTIONS];
  logic signed [PRECISION-1:0] u2_q [CHANNELS][N_SECTIONS];
  logic signed [PRECISION-1:0] v1_q [CHANNELS][N_SECTIONS];
  logic signed [PRECISION-1:0] v2_q [CHANNELS][N_SECTIONS];
  logic signed [PRECISION-1:0] u1_d [CHANNELS][N_SECTIONS];
  logic signed [PRECISION-1:0] u2_d [CHANNELS][N_SECTIONS];
  logic signed [PRECISION-1:0] v1_d [CHANNELS][N_SECTIONS];
  logic signed [PRECISION-1:0] v2_d [CHANNELS][N_SECTIONS];

  logic [CH_WIDTH-1:0]         ch_idx;
  logic signed [PRECISION-1:0] op_data;
  logic signed [COEFF_WIDTH-1:0] op_coef;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     term;
  logic signed [ACC_W-1:0]     acc_base;
  logic signed [ACC_W-1:0]     acc_shift;
  logic signed [PRECISION-1:0] sec_res;
  logic                        accept;

  assign in_ready  = ready_q && (state_q == S_IDLE) && !state_clr;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign y         = y_q;

  // MAC operand select, product and section result (floor shift then reduce)
  always_comb begin
    ch_idx  = (int'(ch_q) < CHANNELS) ? ch_q : '0;
    op_data = u_q;
    case (cnt_q)
      3'd1:    op_data = u1_q[ch_idx][sec_q];
      3'd2:    op_data = u2_q[ch_idx][sec_q];
      3'd3:    op_data = v1_q[ch_idx][sec_q];
      3'd4:    op_data = v2_q[ch_idx][sec_q];
      default: op_data = u_q;
    endcase
    op_coef   = coef_q[(int'(sec_q) * 5 + int'(cnt_q)) * COEFF_WIDTH +: COEFF_WIDTH];
    prod      = op_data * op_coef;
    term      = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_base  = (cnt_q == 3'd0) ? '0 : acc_q;
    acc_shift = acc_q >>> Q;
    sec_res   = reduce_prec(acc_shift);
  end

  // next-state and datapath updates for the sample sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sec_d       = sec_q;
    ch_d        = ch_q;
    ch_ok_d     = ch_ok_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    y_d         = y_q;
    u_d         = u_q;
    coef_d      = coef_q;
    acc_d       = acc_q;
    y_pre_d     = y_pre_q;
    u1_d        = u1_q;
    u2_d        = u2_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    case (state_q)
      S_IDLE: begin
        if (state_clr) begin
          for (int c = 0; c < CHANNELS; c++) begin
            for (int s = 0; s < N_SECTIONS; s++) begin
              u1_d[c][s] = '0;
              u2_d[c][s] = '0;
              v1_d[c][s] = '0;
              v2_d[c][s] = '0;
            end
          end
        end else if (accept) begin
          state_d = S_MAC;
          cnt_d   = 3'd0;
          sec_d   = '0;
          ch_d    = in_ch;
          ch_ok_d = (int'(in_ch) < CHANNELS);
          u_d     = PRECISION'(x);
          coef_d  = packed_coeffs;
        end
      end
      S_MAC: begin
        // taps 0..2 are feed-forward (add), taps 3..4 are feedback (subtract)
        acc_d = (cnt_q < 3'd3) ? (acc_base + term) : (acc_base - term);
        if (cnt_q == 3'd4) begin
          state_d = S_WB;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WB: begin
        // out-of-range channels run the full timing but never touch state
        if (ch_ok_q) begin
          u2_d[ch_idx][sec_q] = u1_q[ch_idx][sec_q];
          u1_d[ch_idx][sec_q] = u_q;
          v2_d[ch_idx][sec_q] = v1_q[ch_idx][sec_q];
          v1_d[ch_idx][sec_q] = sec_res;
        end
        u_d   = sec_res;
        cnt_d = 3'd0;
        if (sec_q == SEC_W'(N_SECTIONS - 1)) begin
          state_d = S_OUT;
        end else begin
          sec_d   = sec_q + SEC_W'(1);
          state_d = S_MAC;
        end
      end
      S_OUT: begin
        // first cycle narrows the final section output, second publishes it
        if (cnt_q == 3'd0) begin
          y_pre_d = reduce_out(u_q);
          cnt_d   = 3'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          if (ch_ok_q) begin
            out_valid_d = 1'b1;
            y_d         = y_pre_q;
            out_ch_d    = ch_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control, output and delay-line registers (cleared by reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sec_q       <= '0;
      ch_q        <= '0;
      ch_ok_q     <= 1'b0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      y_q         <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int s = 0; s < N_SECTIONS; s++) begin
          u1_q[c][s] <= '0;
          u2_q[c][s] <= '0;
          v1_q[c][s] <= '0;
          v2_q[c][s] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sec_q       <= sec_d;
      ch_q        <= ch_d;
      ch_ok_q     <= ch_ok_d;
      ready_q     <= 1'b1;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      y_q         <= y_d;
      u1_q        <= u1_d;
      u2_q        <= u2_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
    end
  end

  // working datapath registers; always loaded before use, so no reset
  always_ff @(posedge clk) begin
    u_q     <= u_d;
    coef_q  <= coef_d;
    acc_q   <= acc_d;
    y_pre_q <= y_pre_d;
  end

endmodule

// File: tb/tb_iir_sos_tdm.sv
// tb_iir_sos_tdm: directed scoreboard bench for iir_sos_tdm (default parameters).
// The driver pushes the expected {channel, y, output cycle} for every sample it
// issues; an independent monitor pops and compares on each out_valid pulse.
module tb_iir_sos_tdm;

  localparam int NS  = 2;
  localparam int CW  = 16;
  localparam int LAT = 6 * NS + 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [0:0]             in_ch;
  logic signed [11:0]     x;
  logic [NS*5*CW-1:0]     coeffs;
  logic                   state_clr;
  logic                   out_valid;
  logic [0:0]             out_ch;
  logic signed [11:0]     y;
  logic                   busy;

  typedef struct {
    int ch;
    int yv;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  iir_sos_tdm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ch         (in_ch),
    .x             (x),
    .packed_coeffs (coeffs),
    .state_clr     (state_clr),
    .out_valid     (out_valid),
    .out_ch        (out_ch),
    .y             (y),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NS*5*CW-1:0] mk(input int b0_s0, input int a1_s0,
                                            input int b0_s1);
    logic [NS*5*CW-1:0] r;
    r = '0;
    r[0*CW +: CW] = CW'(b0_s0);
    r[3*CW +: CW] = CW'(a1_s0);
    r[5*CW +: CW] = CW'(b0_s1);
    return r;
  endfunction

  // monitor: every out_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("y", int'(y), e.yv);
        check("out_ch", int'(out_ch), e.ch);
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input int ch, input int xv, input bit expect_out, input int yexp);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      in_ch    = 1'(ch);
      x        = 12'(xv);
      in_valid = 1'b1;
      if (expect_out) q.push_back('{ch: ch, yv: yexp, cyc: cyc + 1 + LAT});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("busy_after_accept", int'(busy), 1);
    end
  endtask

  task automatic clear_state();
    bit ok;
    wait_ready(ok);
    if (ok) begin
      state_clr = 1'b1;
      in_valid  = 1'b1;
      x         = 12'(777);
      @(posedge clk);
      #1;
      state_clr = 1'b0;
      in_valid  = 1'b0;
      check("clr_blocks_accept_busy", int'(busy), 0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    x         = '0;
    state_clr = 1'b0;
    coeffs    = '0;

    // reset held for 5 cycles: all outputs quiet
    repeat (5) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_y", int'(y), 0);
    check("rst_out_ch", int'(out_ch), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_busy", int'(busy), 0);

    // pass-through: both sections unity gain; coefficient change after accept ignored
    coeffs = mk(16384, 0, 16384);
    send(0, 100, 1'b1, 100);
    send(0, -100, 1'b1, -100);
    coeffs = '0;
    drain();

    // one-pole impulse response in section 0, identity section 1
    clear_state();
    coeffs = mk(16384, -8192, 16384);
    send(0, 1000, 1'b1, 1000);
    send(0, 0, 1'b1, 500);
    send(0, 0, 1'b1, 250);
    send(0, 0, 1'b1, 125);
    drain();

    // channel independence: ch1 silent while ch0 rings
    clear_state();
    send(0, 1000, 1'b1, 1000);
    send(1, 0, 1'b1, 0);
    send(0, 0, 1'b1, 500);
    send(1, 0, 1'b1, 0);
    send(0, 0, 1'b1, 250);
    send(1, 0, 1'b1, 0);
    send(0, 0, 1'b1, 125);
    send(1, 0, 1'b1, 0);
    drain();

    // overflow at the output width: 2047*32767>>14 = 4093
`ifdef IIR_SOS_SAT_EN
    exp_sat = 2047;
`else
    exp_sat = -3;
`endif
    clear_state();
    coeffs = mk(32767, 0, 16384);
    send(0, 2047, 1'b1, exp_sat);
    drain();

    // reset mid-sample: aborted sample yields nothing and state is wiped
    clear_state();
    coeffs = mk(16384, -8192, 16384);
    send(0, 1000, 1'b1, 1000);
    send(0, 1000, 1'b0, 0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    send(0, 1000, 1'b1, 1000);
    drain();

    // state_clr in IDLE wipes the ringing state left by the last sample
    clear_state();
    send(0, 1000, 1'b1, 1000);
    drain();

    repeat (LAT + 4) @(negedge clk);
    check("queue_empty_end", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
